// File: rtl/clock_pkg.sv
// clock_pkg: shared encodings for the CPU clock generator.
//   MODE_*  : values of the clock_gen `mode` input
//   ST_*    : clock FSM state encoding (LOW = c_clk low phase)
package clock_pkg;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_MANUAL = 2'd1;
  localparam logic [1:0] MODE_BURST  = 2'd2;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } clk_state_e;

endpackage

// File: rtl/clk_debounce.sv
// clk_debounce: synchronises and debounces an active-low push-button.
//   sys_clk    in  system clock
//   sys_rst_n  in  async active-low reset
//   btn_n_i    in  raw button, active-low, asynchronous
//   level_o    out debounced pressed level (1 = pressed), registered
//   rise_o     out one-cycle pulse on a debounced press (0->1 of level_o)
// The pressed level must differ from level_o for DEB_CYCLES consecutive
// cycles before level_o follows it.
module clk_debounce #(
  parameter int DEB_CYCLES = 270_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic btn_n_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          raw;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Button idles high, so the synchroniser resets to the released level.
  assign raw = ~sync2_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (raw != level_q) begin
      if (cnt_q == CNT_LAST) level_d = raw;
      else                   cnt_d   = cnt_q + CW'(1);
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/clock_gen.sv
// clock_gen: CPU clock generator (auto / manual single-step / burst).
//   sys_clk, sys_rst_n  system clock, async active-low reset
//   manual_clk          raw step button, active-low
//   mode                0 auto, 1 manual, 2 burst, 3 acts as auto
//   half_period         sys_clk cycles per c_clk phase (0 acts as 1)
//   burst_len           cycles loaded by burst_start
//   burst_start         one-cycle burst trigger (burst mode, idle only)
//   HLT                 hold the clock in its low phase
//   c_clk               generated clock (registered)
//   c_clk_rise/fall     one-cycle strobes coinciding with c_clk edges
//   burst_busy          burst cycles still remaining
// Optional (CLOCK_GEN_CYCLE_COUNTER_EN defined): cycle_count, a wrapping
// 32-bit count of c_clk rises.
module clock_gen
  import clock_pkg::*;
#(
  parameter int DIV_W      = 25,
  parameter int DEB_CYCLES = 270_000,
  parameter int STEP_W     = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              manual_clk,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  half_period,
  input  logic [STEP_W-1:0] burst_len,
  input  logic              burst_start,
  input  logic              HLT,
  output logic              c_clk,
  output logic              c_clk_rise,
  output logic              c_clk_fall,
  output logic              burst_busy
`ifdef CLOCK_GEN_CYCLE_COUNTER_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam logic [DIV_W-1:0]  CNT_ONE = DIV_W'(1);
  localparam logic [STEP_W-1:0] REM_ONE = STEP_W'(1);

  clk_state_e        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, lim_q, lim;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              pend_q, pend_d;
  logic              rise_q, rise_d, fall_q, fall_d;
  logic              btn_level, btn_rise, press;
  logic              expired, rise_ok;

  clk_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .btn_n_i   (manual_clk),
    .level_o   (btn_level),
    .rise_o    (btn_rise)
  );

  assign press = btn_rise & btn_level;

  // The phase length is captured on the first cycle of every phase
  // (counter == 0, including the first cycle out of reset) and held in
  // lim_q, so half_period changes never stretch or cut a running phase.
  assign lim = (cnt_q != '0)        ? lim_q :
               (half_period == '0)  ? '0    : half_period - CNT_ONE;
  assign expired = (cnt_q == lim);

  always_comb begin
    case (mode)
      MODE_MANUAL: rise_ok = pend_q;
      MODE_BURST:  rise_ok = (rem_q != '0);
      default:     rise_ok = 1'b1;  // MODE_AUTO and reserved
    endcase
    rise_ok = rise_ok & ~HLT;
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      lim_q   <= '0;
      rem_q   <= '0;
      pend_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state. A blocked rise leaves the counter parked at its limit so
  // the rise follows one cycle after the condition turns true.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (!expired) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (rise_ok) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!expired) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Outputs and side state.
  always_comb begin
    rise_d = (state_q == ST_LOW)  && (state_d == ST_HIGH);
    fall_d = (state_q == ST_HIGH) && (state_d == ST_LOW);

    pend_d = pend_q;
    if (mode != MODE_MANUAL) pend_d = 1'b0;
    else if (rise_d)         pend_d = 1'b0;
    else if (press)          pend_d = 1'b1;

    rem_d = rem_q;
    if (mode != MODE_BURST)               rem_d = '0;
    else if (rise_d)                      rem_d = rem_q - REM_ONE;
    else if (burst_start && rem_q == '0)  rem_d = burst_len;

    c_clk      = (state_q == ST_HIGH);
    c_clk_rise = rise_q;
    c_clk_fall = fall_q;
    burst_busy = (rem_q != '0);
  end

`ifdef CLOCK_GEN_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  cyc_q <= '0;
    else if (rise_d) cyc_q <= cyc_q + 32'd1;
  end
  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_clock_gen.sv
module tb_clock_gen;

  logic        sys_clk, sys_rst_n, manual_clk, burst_start, HLT;
  logic [1:0]  mode;
  logic [24:0] half_period;
  logic [7:0]  burst_len;
  logic        c_clk, c_clk_rise, c_clk_fall, burst_busy;
`ifdef CLOCK_GEN_CYCLE_COUNTER_EN
  logic [31:0] cycle_count;
`endif

  clock_gen #(.DIV_W(25), .DEB_CYCLES(16), .STEP_W(8)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .manual_clk  (manual_clk),
    .mode        (mode),
    .half_period (half_period),
    .burst_len   (burst_len),
    .burst_start (burst_start),
    .HLT         (HLT),
    .c_clk       (c_clk),
    .c_clk_rise  (c_clk_rise),
    .c_clk_fall  (c_clk_fall),
    .burst_busy  (burst_busy)
`ifdef CLOCK_GEN_CYCLE_COUNTER_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit rise;
    int cyc;
    bit busy;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic exp_edge(input bit r, input int c, input bit b);
    exp_t e;
    e.rise = r; e.cyc = c; e.busy = b;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the next expected edge.
  always @(negedge sys_clk) begin
    if (sys_rst_n && (c_clk_rise || c_clk_fall)) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_edge: cyc=%0d rise=%0b fall=%0b, required no edge",
                 cyc, c_clk_rise, c_clk_fall);
      end else begin
        mon_e = exp_q.pop_front();
        if (c_clk_rise !== mon_e.rise || c_clk_fall !== !mon_e.rise ||
            c_clk !== mon_e.rise || burst_busy !== mon_e.busy || cyc != mon_e.cyc) begin
          mismatched++;
          $display("FAIL edge: got rise=%0b fall=%0b c_clk=%0b busy=%0b cyc=%0d, required rise=%0b busy=%0b cyc=%0d",
                   c_clk_rise, c_clk_fall, c_clk, burst_busy, cyc,
                   mon_e.rise, mon_e.busy, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic check_empty(input string name);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s: got %0d edges still missing (next at cyc %0d), required 0",
               name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  // Asserted between edges so the outputs must clear asynchronously.
  task automatic do_reset(output int rel);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_c_clk", {31'd0, c_clk}, 0);
    chk("rst_rise",  {31'd0, c_clk_rise}, 0);
    chk("rst_fall",  {31'd0, c_clk_fall}, 0);
    chk("rst_busy",  {31'd0, burst_busy}, 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    rel = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1, p, x, y;
    sys_rst_n = 1'b0; manual_clk = 1'b1; mode = 2'd0; half_period = 25'd3;
    burst_len = 8'd0; burst_start = 1'b0; HLT = 1'b0;
    @(negedge sys_clk);

    // Auto, half_period 3: period 6, first rise 3 cycles after reset.
    do_reset(r0);
    for (int k = 0; k < 3; k++) begin
      exp_edge(1, r0 + 3 + 6*k, 0);
      exp_edge(0, r0 + 6 + 6*k, 0);
    end
    wait_until(r0 + 19);
    check_empty("auto_hp3");

    // Auto, half_period 4, HLT raised after a rise.
    half_period = 25'd4;
    do_reset(r0);
    exp_edge(1, r0 + 4, 0);
    exp_edge(0, r0 + 8, 0);
    wait_until(r0 + 4);  HLT = 1'b1;
    wait_until(r0 + 15); chk("hlt_hold_low", {31'd0, c_clk}, 0);
    wait_until(r0 + 20);
    exp_edge(1, r0 + 21, 0);
    exp_edge(0, r0 + 25, 0);
    HLT = 1'b0;
    wait_until(r0 + 22); HLT = 1'b1;
    wait_until(r0 + 30);
    check_empty("auto_hlt");

    // Manual, half_period 80, glitch then two presses.
    HLT = 1'b0; mode = 2'd1; half_period = 25'd80;
    do_reset(r0);
    wait_until(r0 + 5);  manual_clk = 1'b0;
    wait_until(r0 + 10); manual_clk = 1'b1;
    wait_until(r0 + 80);
    p = cyc;
    manual_clk = 1'b0;
    exp_edge(1, p + 20, 0);
    exp_edge(0, p + 100, 0);
    exp_edge(1, p + 180, 0);
    exp_edge(0, p + 260, 0);
    wait_until(p + 40);  manual_clk = 1'b1;
    wait_until(p + 60);  manual_clk = 1'b0;
    wait_until(p + 100); manual_clk = 1'b1;
    wait_until(p + 280);
    check_empty("manual");

    // Burst of 3 at half_period 2, restart mid-burst ignored.
    mode = 2'd2; half_period = 25'd2;
    do_reset(r0);
    exp_edge(1, r0 + 7, 1);  exp_edge(0, r0 + 9, 1);
    exp_edge(1, r0 + 11, 1); exp_edge(0, r0 + 13, 1);
    exp_edge(1, r0 + 15, 0); exp_edge(0, r0 + 17, 0);
    wait_until(r0 + 5);
    burst_len = 8'd3; burst_start = 1'b1;
    @(negedge sys_clk); burst_start = 1'b0;
    chk("burst_busy_load", {31'd0, burst_busy}, 1);
    wait_until(r0 + 10);
    burst_len = 8'd7; burst_start = 1'b1;
    @(negedge sys_clk); burst_start = 1'b0;
    wait_until(r0 + 30);
    check_empty("burst3");
    chk("burst_done_busy", {31'd0, burst_busy}, 0);

    // Zero-length burst, then switch to auto mid-burst.
    x = cyc;
    burst_len = 8'd0; burst_start = 1'b1;
    @(negedge sys_clk); burst_start = 1'b0;
    wait_until(x + 3);
    chk("burst0_busy", {31'd0, burst_busy}, 0);
    wait_until(x + 10);
    y = cyc;
    burst_len = 8'd5; burst_start = 1'b1;
    exp_edge(1, y + 2, 1);
    exp_edge(0, y + 4, 0);
    exp_edge(1, y + 6, 0);
    @(negedge sys_clk); burst_start = 1'b0;
    wait_until(y + 2); mode = 2'd0;
    wait_until(y + 3);
    chk("abort_busy", {31'd0, burst_busy}, 0);
    wait_until(y + 7);
    check_empty("burst_abort");
    chk("pre_rst_high", {31'd0, c_clk}, 1);

    // Reset during HIGH (busy burst), then auto restart with half_period 3.
    mode = 2'd2; half_period = 25'd3;
    do_reset(r0);
    wait_until(r0 + 3);
    burst_len = 8'd5; burst_start = 1'b1;
    exp_edge(1, r0 + 5, 1);
    @(negedge sys_clk); burst_start = 1'b0;
    wait_until(r0 + 6);
    chk("pre_rst_busy", {31'd0, burst_busy}, 1);
    mode = 2'd0;
    do_reset(r1);
    exp_edge(1, r1 + 3, 0);
    exp_edge(0, r1 + 6, 0);
    exp_edge(1, r1 + 9, 0);
    exp_edge(0, r1 + 12, 0);
    wait_until(r1 + 10); HLT = 1'b1;
    wait_until(r1 + 20);
    check_empty("post_reset");
    chk("final_low", {31'd0, c_clk}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
